// File: rtl/rpsc_pkg.sv
// ---------------------------------------------------------------------------
// rpsc_pkg
// Shared types and default timing constants for the RPSC front-panel fault
// sequencer.
//   rpsc_seq_state_e : sequencer FSM states (IDLE, RST_PULSE, LAMP_TEST)
//   DEFAULT_*        : default parameter values used by the sequencer blocks
//   max3()           : helper used to size the shared pulse counter
// ---------------------------------------------------------------------------
package rpsc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RST_PULSE = 2'd1,
        LAMP_TEST = 2'd2
    } rpsc_seq_state_e;

    localparam int DEFAULT_N_FAULTS           = 8;
    localparam int DEFAULT_DEBOUNCE_CYCLES    = 16;
    localparam int DEFAULT_RESET_PULSE_CYCLES = 4;
    localparam int DEFAULT_LAMP_TEST_CYCLES   = 1000;

    // Largest of three integers; used for counter sizing at elaboration.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/rpsc_debounce.sv
// ---------------------------------------------------------------------------
// rpsc_debounce
// Synchronises one raw pushbutton into clk, debounces it and emits a single
// cycle request on each rising edge of the debounced level.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset (debounced level returns to 0)
//   btn    in  raw asynchronous button, active-high
//   req    out one-cycle pulse on each accepted press
// ---------------------------------------------------------------------------
module rpsc_debounce
    import rpsc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic req
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             meta_reg;
    logic             sync_reg;
    logic             level_reg;
    logic             level_prev_reg;
    logic [CNT_W-1:0] cnt_reg;

    // The counter tracks how many consecutive cycles the synchronised level
    // has disagreed with the accepted level. Any agreement restarts it, so
    // bounces shorter than DEBOUNCE_CYCLES never reach the flip point.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg       <= 1'b0;
            sync_reg       <= 1'b0;
            level_reg      <= 1'b0;
            level_prev_reg <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            meta_reg       <= btn;
            sync_reg       <= meta_reg;
            level_prev_reg <= level_reg;
            if (sync_reg != level_reg) begin
                if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_reg <= sync_reg;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    // Decoded from flops only; the sequencer registers its reaction.
    assign req = level_reg & ~level_prev_reg;

endmodule

// File: rtl/rpsc_fault_sequencer.sv
// ---------------------------------------------------------------------------
// rpsc_fault_sequencer
// Rack-level front-panel controller for the RPSC protection cards. Debounces
// the RESET and LAMP TEST buttons, sequences timed card reset / lamp-test
// pulses, withholds the hold-error clear while faults are present and
// latches the first fault seen since the last hold-error clear.
// Ports:
//   clk                   in  system clock
//   reset                 in  synchronous active-high reset
//   reset_btn             in  raw RESET button (async, active-high)
//   lamp_test_btn         in  raw LAMP TEST button (async, active-high)
//   fault_in              in  raw fault inputs (async, active-high)
//   card_reset            out card reset strobe
//   card_reset_hold_error out card hold-error clear strobe
//   LA_Test               out lamp-test drive
//   hold_err_blocked      out one-cycle pulse when a hold-error clear is refused
//   first_fault_valid     out a first fault is latched
//   first_fault_idx       out index of the latched first fault
//   busy                  out sequencer not idle
// All outputs are driven straight from flops.
// ---------------------------------------------------------------------------
module rpsc_fault_sequencer
    import rpsc_pkg::*;
#(
    parameter int N_FAULTS           = DEFAULT_N_FAULTS,
    parameter int DEBOUNCE_CYCLES    = DEFAULT_DEBOUNCE_CYCLES,
    parameter int RESET_PULSE_CYCLES = DEFAULT_RESET_PULSE_CYCLES,
    parameter int LAMP_TEST_CYCLES   = DEFAULT_LAMP_TEST_CYCLES,
    parameter int IDX_W              = $clog2(N_FAULTS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reset_btn,
    input  logic                lamp_test_btn,
    input  logic [N_FAULTS-1:0] fault_in,
    output logic                card_reset,
    output logic                card_reset_hold_error,
    output logic                LA_Test,
    output logic                hold_err_blocked,
    output logic                first_fault_valid,
    output logic [IDX_W-1:0]    first_fault_idx,
    output logic                busy
);

    localparam int CNT_MAX = max3(RESET_PULSE_CYCLES, LAMP_TEST_CYCLES, DEBOUNCE_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // -----------------------------------------------------------------------
    // Button front ends
    // -----------------------------------------------------------------------
    logic reset_req;
    logic lamp_req;

    rpsc_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_reset_db (
        .clk   (clk),
        .reset (reset),
        .btn   (reset_btn),
        .req   (reset_req)
    );

    rpsc_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_lamp_db (
        .clk   (clk),
        .reset (reset),
        .btn   (lamp_test_btn),
        .req   (lamp_req)
    );

    // -----------------------------------------------------------------------
    // Fault synchronisers (no debounce: a fault must be seen immediately)
    // -----------------------------------------------------------------------
    logic [N_FAULTS-1:0] fault_sync;

    generate
        for (genvar gi = 0; gi < N_FAULTS; gi++) begin : g_fault_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= fault_in[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign fault_sync[gi] = sync_reg;
        end
    endgenerate

    logic             fault_any;
    logic [IDX_W-1:0] fault_lowest;

    assign fault_any = |fault_sync;

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        fault_lowest = '0;
        for (int i = N_FAULTS - 1; i >= 0; i--) begin
            if (fault_sync[i]) begin
                fault_lowest = IDX_W'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer FSM with shared pulse counter
    // -----------------------------------------------------------------------
    rpsc_seq_state_e state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             hold_ok_reg, hold_ok_next;
    logic             entering_rst;

    logic card_reset_reg, card_reset_next;
    logic hold_err_reg, hold_err_next;
    logic la_test_reg, la_test_next;
    logic blocked_reg, blocked_next;
    logic busy_reg, busy_next;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        entering_rst = 1'b0;

        case (state_reg)
            IDLE: begin
                // Reset outranks a lamp request arriving on the same cycle.
                if (reset_req) begin
                    state_next   = RST_PULSE;
                    cnt_next     = CNT_W'(RESET_PULSE_CYCLES - 1);
                    entering_rst = 1'b1;
                end else if (lamp_req) begin
                    state_next = LAMP_TEST;
                    cnt_next   = CNT_W'(LAMP_TEST_CYCLES - 1);
                end
            end
            RST_PULSE: begin
                // New requests are ignored; the pulse is never stretched.
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            LAMP_TEST: begin
                // A reset press aborts the lamp test immediately.
                if (reset_req) begin
                    state_next   = RST_PULSE;
                    cnt_next     = CNT_W'(RESET_PULSE_CYCLES - 1);
                    entering_rst = 1'b1;
                end else if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // The hold-error decision is frozen on the entry cycle for the
        // whole pulse, so faults changing mid-pulse cannot chop it.
        hold_ok_next = entering_rst ? ~fault_any : hold_ok_reg;

        // Outputs are decoded from the next state and registered, so each
        // strobe starts and stops exactly on the state transition edges.
        card_reset_next = (state_next == RST_PULSE);
        hold_err_next   = (state_next == RST_PULSE) && hold_ok_next;
        la_test_next    = (state_next == LAMP_TEST);
        blocked_next    = entering_rst && fault_any;
        busy_next       = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            hold_ok_reg    <= 1'b0;
            card_reset_reg <= 1'b0;
            hold_err_reg   <= 1'b0;
            la_test_reg    <= 1'b0;
            blocked_reg    <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            hold_ok_reg    <= hold_ok_next;
            card_reset_reg <= card_reset_next;
            hold_err_reg   <= hold_err_next;
            la_test_reg    <= la_test_next;
            blocked_reg    <= blocked_next;
            busy_reg       <= busy_next;
        end
    end

    // -----------------------------------------------------------------------
    // First-fault latch: cleared while the cards see the hold-error clear,
    // which takes priority over a capture on the same cycle.
    // -----------------------------------------------------------------------
    logic             ff_valid_reg;
    logic [IDX_W-1:0] ff_idx_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            ff_valid_reg <= 1'b0;
            ff_idx_reg   <= '0;
        end else if (hold_err_reg) begin
            ff_valid_reg <= 1'b0;
            ff_idx_reg   <= '0;
        end else if (!ff_valid_reg && fault_any) begin
            ff_valid_reg <= 1'b1;
            ff_idx_reg   <= fault_lowest;
        end
    end

    assign card_reset            = card_reset_reg;
    assign card_reset_hold_error = hold_err_reg;
    assign LA_Test               = la_test_reg;
    assign hold_err_blocked      = blocked_reg;
    assign busy                  = busy_reg;
    assign first_fault_valid     = ff_valid_reg;
    assign first_fault_idx       = ff_idx_reg;

endmodule

// File: tb/tb_rpsc_fault_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rpsc_fault_sequencer
// Directed bench for rpsc_fault_sequencer. The stimulus process pushes the
// pulse it expects (kind, start edge, width, hold-error cycles, blocked
// pulses, latch state at the end) into a queue; a monitor reconstructs every
// pulse the DUT actually produces and compares it against the queue head.
// ---------------------------------------------------------------------------
module tb_rpsc_fault_sequencer;

    localparam int KIND_RST  = 1;
    localparam int KIND_LAMP = 2;
    localparam int DB_LAT    = 18;   // first sample edge -> pulse start edge

    logic       clk = 1'b0;
    logic       reset;
    logic       reset_btn;
    logic       lamp_test_btn;
    logic [7:0] fault_in;
    logic       card_reset;
    logic       card_reset_hold_error;
    logic       LA_Test;
    logic       hold_err_blocked;
    logic       first_fault_valid;
    logic [2:0] first_fault_idx;
    logic       busy;

    rpsc_fault_sequencer dut (
        .clk                   (clk),
        .reset                 (reset),
        .reset_btn             (reset_btn),
        .lamp_test_btn         (lamp_test_btn),
        .fault_in              (fault_in),
        .card_reset            (card_reset),
        .card_reset_hold_error (card_reset_hold_error),
        .LA_Test               (LA_Test),
        .hold_err_blocked      (hold_err_blocked),
        .first_fault_valid     (first_fault_valid),
        .first_fault_idx       (first_fault_idx),
        .busy                  (busy)
    );

    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc equals the number of posedges so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int kind;
        int start;
        int width;
        int hold;
        int blk;
        int busy_cnt;
        int ffv;
        int idx;
    } pulse_t;

    pulse_t exp_q[$];
    int     pulses_exp  = 0;
    int     pulses_seen = 0;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input int kind, input int start, input int width,
                            input int hold, input int blk, input int ffv, input int idx);
        pulse_t p;
        p.kind     = kind;
        p.start    = start;
        p.width    = width;
        p.hold     = hold;
        p.blk      = blk;
        p.busy_cnt = width;
        p.ffv      = ffv;
        p.idx      = idx;
        exp_q.push_back(p);
        pulses_exp++;
    endtask

    // -----------------------------------------------------------------------
    // Monitor
    // -----------------------------------------------------------------------
    int     cur_kind = 0;
    pulse_t obs;

    task automatic finish_pulse();
        pulse_t e;
        obs.ffv = int'(first_fault_valid);
        obs.idx = int'(first_fault_idx);
        pulses_seen++;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_pulse: kind %0d start %0d width %0d, none expected",
                     obs.kind, obs.start, obs.width);
        end else begin
            e = exp_q.pop_front();
            chk("pulse_kind",  obs.kind,     e.kind);
            chk("pulse_start", obs.start,    e.start);
            chk("pulse_width", obs.width,    e.width);
            chk("hold_cycles", obs.hold,     e.hold);
            chk("blocked_cnt", obs.blk,      e.blk);
            chk("busy_cycles", obs.busy_cnt, e.busy_cnt);
            chk("ff_valid",    obs.ffv,      e.ffv);
            chk("ff_idx",      obs.idx,      e.idx);
            $display("[TB] pulse kind=%0d start=%0d width=%0d hold=%0d blk=%0d ffv=%0d idx=%0d",
                     obs.kind, obs.start, obs.width, obs.hold, obs.blk, obs.ffv, obs.idx);
        end
    endtask

    always @(negedge clk) begin
        int k;
        k = card_reset ? KIND_RST : (LA_Test ? KIND_LAMP : 0);
        if (k != cur_kind) begin
            if (cur_kind != 0) finish_pulse();
            if (k != 0) begin
                obs.kind     = k;
                obs.start    = cyc;
                obs.width    = 0;
                obs.hold     = 0;
                obs.blk      = 0;
                obs.busy_cnt = 0;
            end
            cur_kind = k;
        end
        if (k != 0) begin
            obs.width++;
            obs.hold     += int'(card_reset_hold_error);
            obs.blk      += int'(hold_err_blocked);
            obs.busy_cnt += int'(busy);
        end else if (busy || card_reset_hold_error || hold_err_blocked) begin
            tests++;
            fails++;
            $display("[TB] FAIL idle_outputs: busy=%0b hold=%0b blk=%0b expected all 0 (edge %0d)",
                     busy, card_reset_hold_error, hold_err_blocked, cyc);
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int edge_n);
        while (cyc < edge_n) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_card_reset"}, int'(card_reset), 0);
        chk({tag, "_hold_err"},   int'(card_reset_hold_error), 0);
        chk({tag, "_la_test"},    int'(LA_Test), 0);
        chk({tag, "_blocked"},    int'(hold_err_blocked), 0);
        chk({tag, "_ff_valid"},   int'(first_fault_valid), 0);
        chk({tag, "_ff_idx"},     int'(first_fault_idx), 0);
        chk({tag, "_busy"},       int'(busy), 0);
    endtask

    // Press a single button for 30 cycles; returns the first sample edge.
    task automatic press(input bit use_reset, output int t0);
        t0 = cyc + 1;
        if (use_reset) reset_btn = 1'b1;
        else           lamp_test_btn = 1'b1;
        wait_cyc(30);
        reset_btn     = 1'b0;
        lamp_test_btn = 1'b0;
    endtask

    initial begin
        int t0;
        reset         = 1'b1;
        reset_btn     = 1'b0;
        lamp_test_btn = 1'b0;
        fault_in      = 8'h00;
        wait_cyc(5);
        chk_all_zero("reset_state");
        reset = 1'b0;
        wait_cyc(5);

        // Clean reset press, no faults.
        t0 = cyc + 1;
        push_exp(KIND_RST, t0 + DB_LAT, 4, 4, 0, 0, 0);
        press(1'b1, t0);
        wait_cyc(40);

        // Bounce shorter than the debounce window: nothing may fire.
        reset_btn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wait_cyc(5);
            reset_btn = ~reset_btn;
        end
        reset_btn = 1'b0;
        wait_cyc(40);
        chk("bounce_pulses", pulses_seen, pulses_exp);

        // Faults present: clear refused, first fault = bit 2.
        fault_in = 8'b0010_0100;
        wait_cyc(5);
        chk("latch2_valid", int'(first_fault_valid), 1);
        chk("latch2_idx",   int'(first_fault_idx), 2);
        t0 = cyc + 1;
        push_exp(KIND_RST, t0 + DB_LAT, 4, 0, 1, 1, 2);
        press(1'b1, t0);
        wait_cyc(40);
        fault_in = 8'h80;
        wait_cyc(5);
        chk("latch_hold_valid", int'(first_fault_valid), 1);
        chk("latch_hold_idx",   int'(first_fault_idx), 2);

        // Faults gone: clear accepted, latch cleared.
        fault_in = 8'h00;
        wait_cyc(5);
        t0 = cyc + 1;
        push_exp(KIND_RST, t0 + DB_LAT, 4, 4, 0, 0, 0);
        press(1'b1, t0);
        wait_cyc(40);

        // Capture of the top bit after the clear.
        fault_in = 8'h80;
        wait_cyc(5);
        chk("latch7_valid", int'(first_fault_valid), 1);
        chk("latch7_idx",   int'(first_fault_idx), 7);
        fault_in = 8'h00;
        wait_cyc(5);

        // Lamp test aborted by a reset press 100 cycles into it.
        t0 = cyc + 1;
        push_exp(KIND_LAMP, t0 + DB_LAT, 118, 0, 0, 1, 7);
        push_exp(KIND_RST,  t0 + DB_LAT + 118, 4, 4, 0, 0, 0);
        lamp_test_btn = 1'b1;
        wait_cyc(30);
        lamp_test_btn = 1'b0;
        wait_until(t0 + DB_LAT + 100 - 1);
        reset_btn = 1'b1;
        wait_cyc(30);
        reset_btn = 1'b0;
        wait_cyc(40);

        // Full-length lamp test.
        t0 = cyc + 1;
        push_exp(KIND_LAMP, t0 + DB_LAT, 1000, 0, 0, 0, 0);
        press(1'b0, t0);
        wait_until(t0 + DB_LAT + 1000 + 40);

        // Both buttons together, then global reset one cycle into the pulse.
        t0 = cyc + 1;
        push_exp(KIND_RST, t0 + DB_LAT, 1, 1, 0, 0, 0);
        reset_btn     = 1'b1;
        lamp_test_btn = 1'b1;
        wait_until(t0 + DB_LAT);
        chk("simul_card_reset", int'(card_reset), 1);
        chk("simul_la_test",    int'(LA_Test), 0);
        reset         = 1'b1;
        reset_btn     = 1'b0;
        lamp_test_btn = 1'b0;
        wait_cyc(1);
        chk_all_zero("midpulse_reset");
        reset = 1'b0;
        wait_cyc(60);

        chk("pending_expected", exp_q.size(), 0);
        chk("pulse_count", pulses_seen, pulses_exp);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
